// File: rtl/vga_window_scan.sv
// VGA raster engine: scans a centred 2x-scaled 128x128 window out of the frame
// buffer and emits sync, blanking and colour aligned after the buffer's read latency.
module vga_window_scan #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          WIN_X    = 192,
  parameter int          WIN_Y    = 112,
  parameter logic [11:0] BORDER   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [6:0]  row,
  output logic [6:0]  col,
  output logic        oe,
  input  logic [11:0] rgb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int WIN_SIZE = 256;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] WX_FIRST = 10'(WIN_X);
  localparam logic [9:0] WX_LAST  = 10'(WIN_X + WIN_SIZE - 1);
  localparam logic [9:0] WY_FIRST = 10'(WIN_Y);
  localparam logic [9:0] WY_LAST  = 10'(WIN_Y + WIN_SIZE - 1);

  logic [9:0] h_cnt, v_cnt;
  logic       active0, hs0, vs0, win0, first0;
  logic       de1, hs1, vs1, win1, first1;
  logic [11:0] bgr2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Stage 0: timing decode and buffer addressing straight off the counters
  always_comb begin
    active0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0     = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vs0     = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    win0    = (h_cnt >= WX_FIRST) && (h_cnt <= WX_LAST) &&
              (v_cnt >= WY_FIRST) && (v_cnt <= WY_LAST);
    first0  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    col     = 7'((h_cnt - WX_FIRST) >> 1);
    row     = 7'((v_cnt - WY_FIRST) >> 1);
    oe      = win0;
  end

  // Stage 1 waits alongside the buffer's one-cycle read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de1    <= 1'b0;
      hs1    <= 1'b1;
      vs1    <= 1'b1;
      win1   <= 1'b0;
      first1 <= 1'b0;
    end else begin
      de1    <= active0;
      hs1    <= hs0;
      vs1    <= vs0;
      win1   <= win0;
      first1 <= first0;
    end
  end

  // Buffer data is only trusted under win1; it holds stale words elsewhere
  always_comb begin
    if (!de1)
      bgr2 = 12'h000;
    else if (win1)
      bgr2 = rgb;
    else
      bgr2 = BORDER;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
      vga_b       <= 4'h0;
      vga_g       <= 4'h0;
      vga_r       <= 4'h0;
    end else begin
      vga_hs      <= hs1;
      vga_vs      <= vs1;
      vga_de      <= de1;
      frame_start <= first1;
      vga_b       <= bgr2[11:8];
      vga_g       <= bgr2[7:4];
      vga_r       <= bgr2[3:0];
    end
  end

endmodule

// File: doc/vga_window_scan.md
# vga_window_scan

VGA 640x480@60 raster engine that drives the read side of the 128x128x12-bit BRAM frame buffer and turns its output into VGA pixels. Generates horizontal/vertical timing, maps a centred 256x256 on-screen window (128x128 buffer shown at 2x scale) to buffer `row`/`col`/`oe`, and consumes the buffer's registered 12-bit BGR word. Compensates the buffer's one-cycle read latency so that sync, blanking and colour leave the block aligned. Sits between the frame buffer and the DVI/VGA output encoder.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- WIN_X, 192, first visible x of window
- WIN_Y, 112, first visible y of window
- BORDER, 12'h000, BGR colour outside the window within the active area

- clk  in  1  pixel clock (25 MHz nominal); one pixel per cycle
- reset  in  1  asynchronous, active-low reset
- row  out  7  buffer row address
- col  out  7  buffer column address
- oe  out  1  buffer read enable
- rgb  in  12  buffer read data, BGR: [11:8]=B, [7:4]=G, [3:0]=R; valid one cycle after `oe`
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_de  out  1  active-video flag
- frame_start  out  1  one-cycle pulse aligned with output of pixel (0,0)

## Operation
- Counters: `h_cnt` 0..H_TOTAL-1 (H_TOTAL=800), `v_cnt` 0..V_TOTAL-1 (V_TOTAL=525). `h_cnt` increments every cycle; on wrap to 0 `v_cnt` increments; `v_cnt` wraps to 0 after 524. Both 10 bits.
- Stage 0 (combinational from counters): active = h_cnt<640 && v_cnt<480; hs0 low for 656<=h_cnt<=751; vs0 low for 490<=v_cnt<=491; win = 192<=h_cnt<=447 && 112<=v_cnt<=367.
- Addressing (combinational): col=(h_cnt-WIN_X)>>1, row=(v_cnt-WIN_Y)>>1, truncated to 7 bits; oe=win. Outside the window row/col are don't-care, but oe must be 0.
- Stage 1 (registered): active, hs0, vs0, win, first-pixel flag (h_cnt==0 && v_cnt==0) delayed one cycle; buffer supplies `rgb` in this same cycle.
- Stage 2 (registered outputs): vga_hs/vga_vs/vga_de/frame_start from stage 1. Colour: if !de1 -> 0; else if win1 -> rgb fields; else BORDER fields. Blanked pixels are always 0.
- The buffer holds `rgb` while oe=0; the block must never forward stale `rgb` outside the window (gate with win1, not with rgb).
- Each buffer pixel spans 2 consecutive x and 2 consecutive y.

## Timing
- Latency counter->pins: 2 cycles for all outputs; sync, de and colour for the same pixel leave on the same edge.
- row/col/oe change in the same cycle as the counters (0-cycle).
- Reset (async assert, reset=0): h_cnt=v_cnt=0; vga_hs=vga_vs=1; vga_de=0; vga_r/g/b=0; frame_start=0; stage-1 registers cleared to inactive (hs/vs=1). oe is 0 during reset (counters at 0,0 lie outside the window).
- Release: first rising edge with reset=1 advances h_cnt to 1; frame_start fires 2 cycles after the first edge sampling h_cnt=0,v_cnt=0 after reset, then every 420000 cycles.
- Reset mid-frame: counters and pipeline clear immediately; no partial sync pulse is stretched.
- Frame period 800*525=420000 cycles; line period 800 cycles.

## Test plan
- Reset held then released -> outputs at reset values; frame_start first at cycle 2 after release, then every 420000 cycles exactly.
- Count one full frame -> vga_hs low for 96 cycles per line starting 2 cycles after h_cnt=656; vga_vs low for exactly 1600 cycles; vga_de high 640x480=307200 cycles per frame.
- Address sweep -> at h_cnt=192,193,194 on v_cnt=112: col=0,0,1, row=0, oe=1; at h_cnt=447: col=127; v_cnt=367: row=127; oe=0 at h_cnt=191 and 448.
- Buffer model (1-cycle registered, top half 12'h00F, bottom 12'hF00) -> vga_r=F in window lines 112..239, vga_b=F in lines 240..367, BORDER (0) elsewhere in active area, 0 in blanking.
- Stale data: buffer model outputs 12'hFFF held after last window pixel -> vga_r/g/b=0 at h_cnt 448..639 outputs.
- Async reset asserted mid-line (h_cnt=300,v_cnt=200) -> all outputs at reset values before next clock edge; restart from (0,0).
